trap_reporter: RTL and testbench

//  Producer side of the simulation trap/monitor interface. Sits at the core commit stage,

---
 rtl/nutshell_trap_pkg.sv | 18 +
 rtl/trap_watchdog.sv | 37 +++
 rtl/trap_reporter.sv | 155 +++++++++++++++
 tb/tb_trap_reporter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nutshell_trap_pkg.sv
// Shared types and constants for the NutShell simulation trap reporter.
// The decode helper shows how commit_is_trap is formed upstream.
package nutshell_trap_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } trapState_e;

  localparam logic [31:0] WDOG_CODE   = 32'h0000_DEAD;
  localparam logic [6:0]  TRAP_OPCODE = 7'h6b;

  function automatic logic isTrapInsn(input logic [31:0] insn);
    return insn[6:0] == TRAP_OPCODE;
  endfunction

endpackage

// File: rtl/trap_watchdog.sv
// Commit-stall watchdog: counts consecutive idle cycles while enabled and flags
// expiry on the cycle the idle count reaches TIMEOUT. TIMEOUT==0 removes it.
module trap_watchdog #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic kick,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : gNoWdog
      assign expire = 1'b0;
    end else begin : gWdog
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] countReg;

      // Expiry is judged on the pre-increment count, so the TIMEOUT-th idle cycle fires.
      assign expire = en && !kick && (countReg == CW'(TIMEOUT - 1));

      always_ff @(posedge clk) begin
        if (!reset) begin
          countReg <= '0;
        end else if (en) begin
          if (kick) begin
            countReg <= '0;
          end else if (!expire) begin
            countReg <= countReg + CW'(1);
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/trap_reporter.sv
// Commit-stage trap reporter: counts cycles and retirements, catches the trap
// instruction or a commit-stall timeout, halts commit, drains, then latches a report.
module trap_reporter
  import nutshell_trap_pkg::*;
#(
  parameter int unsigned COMMIT_W  = 2,
  parameter int unsigned TIMEOUT   = 5000,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COMMIT_W-1:0]   commit_valid,
  input  logic [COMMIT_W*64-1:0] commit_pc,
  input  logic [COMMIT_W-1:0]   commit_is_trap,
  input  logic [COMMIT_W*64-1:0] commit_a0,
  output logic                  halt_req,
  output logic                  isNutShellTrap,
  output logic [31:0]           trapCode,
  output logic [63:0]           trapPC,
  output logic [63:0]           cycleCnt,
  output logic [63:0]           instrCnt
);

  localparam int IW = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  trapState_e          stateReg, stateNext;
  logic [DW-1:0]       drainReg, drainNext;
  logic                haltReg, haltNext;
  logic                trapReg, trapNext;
  logic [31:0]         codeReg, codeNext;
  logic [63:0]         pcReg, pcNext;
  logic [63:0]         cycleReg, cycleNext;
  logic [63:0]         instrCntReg, instrNext;

  logic [63:0]         slotPc   [COMMIT_W];
  logic [31:0]         slotCode [COMMIT_W];
  logic [COMMIT_W*32-1:0] a0Hi;
  logic                unusedA0Hi;

  logic                trapFound;
  logic [IW-1:0]       trapIdx;
  logic [IW-1:0]       lastIdx;
  logic [63:0]         commitInc;
  logic                wdogExpire;

  for (genvar gi = 0; gi < COMMIT_W; gi++) begin : gSlot
    assign slotPc[gi]            = commit_pc[64*gi +: 64];
    assign slotCode[gi]          = commit_a0[64*gi +: 32];
    assign a0Hi[32*gi +: 32]     = commit_a0[64*gi+32 +: 32];
  end
  assign unusedA0Hi = ^a0Hi;

  // Oldest trapping slot wins; younger slots behind it never retire.
  always_comb begin
    trapFound = 1'b0;
    trapIdx   = '0;
    lastIdx   = '0;
    commitInc = '0;
    for (int i = COMMIT_W - 1; i >= 0; i--) begin
      if (commit_valid[i] && commit_is_trap[i]) begin
        trapFound = 1'b1;
        trapIdx   = IW'(i);
      end
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid[i]) lastIdx = IW'(i);
      if (commit_valid[i] && (!trapFound || i <= int'(trapIdx))) begin
        commitInc = commitInc + 64'd1;
      end
    end
  end

  trap_watchdog #(.TIMEOUT(TIMEOUT)) uWdog (
    .clk    (clk),
    .reset  (reset),
    .en     (stateReg == RUN),
    .kick   (|commit_valid),
    .expire (wdogExpire)
  );

  always_comb begin
    stateNext = stateReg;
    drainNext = drainReg;
    haltNext  = haltReg;
    trapNext  = trapReg;
    codeNext  = codeReg;
    pcNext    = pcReg;
    cycleNext = cycleReg;
    instrNext = instrCntReg;
    unique case (stateReg)
      RUN: begin
        cycleNext = cycleReg + 64'd1;
        instrNext = instrCntReg + commitInc;
        if (trapFound) begin
          codeNext  = slotCode[trapIdx];
          pcNext    = slotPc[trapIdx];
          haltNext  = 1'b1;
          drainNext = '0;
          stateNext = DRAIN;
        end else begin
          if (|commit_valid) pcNext = slotPc[lastIdx];
          if (wdogExpire) begin
            codeNext  = WDOG_CODE;
            haltNext  = 1'b1;
            drainNext = '0;
            stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Late commits are dropped here; the core should already be stalled.
        cycleNext = cycleReg + 64'd1;
        if (drainReg == DW'(DRAIN_CYC - 1)) begin
          trapNext  = 1'b1;
          stateNext = HALT;
        end else begin
          drainNext = drainReg + DW'(1);
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg    <= RUN;
      drainReg    <= '0;
      haltReg     <= 1'b0;
      trapReg     <= 1'b0;
      codeReg     <= '0;
      pcReg       <= '0;
      cycleReg    <= '0;
      instrCntReg <= '0;
    end else begin
      stateReg    <= stateNext;
      drainReg    <= drainNext;
      haltReg     <= haltNext;
      trapReg     <= trapNext;
      codeReg     <= codeNext;
      pcReg       <= pcNext;
      cycleReg    <= cycleNext;
      instrCntReg <= instrNext;
    end
  end

  assign halt_req       = haltReg;
  assign isNutShellTrap = trapReg;
  assign trapCode       = codeReg;
  assign trapPC         = pcReg;
  assign cycleCnt       = cycleReg;
  assign instrCnt       = instrCntReg;

endmodule

// File: tb/tb_trap_reporter.sv
// Bench for trap_reporter: directed scenarios plus randomized commit traffic,
// all compared against a cycle-level reference model of the reporting rules.
module tb_trap_reporter;

  localparam int TIMEOUT   = 16;
  localparam int DRAIN_CYC = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   commit_valid, commit_is_trap;
  logic [127:0] commit_pc, commit_a0;
  logic         halt_req, isNutShellTrap;
  logic [31:0]  trapCode;
  logic [63:0]  trapPC, cycleCnt, instrCnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trap_reporter #(.COMMIT_W(2), .TIMEOUT(TIMEOUT), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk            (clk),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .commit_is_trap (commit_is_trap),
    .commit_a0      (commit_a0),
    .halt_req       (halt_req),
    .isNutShellTrap (isNutShellTrap),
    .trapCode       (trapCode),
    .trapPC         (trapPC),
    .cycleCnt       (cycleCnt),
    .instrCnt       (instrCnt)
  );

  // Reference model: a trap is remembered together with the cycle number at
  // which its report becomes visible; everything freezes once reported.
  logic        mHalt = 0, mTrapped = 0, mReported = 0;
  logic [31:0] mCode = 0;
  logic [63:0] mPc = 0, mCycle = 0, mInstr = 0, mReportAt = 0;
  int          mIdle = 0;

  task automatic model_clock();
    int firstTrap;
    int nKeep;
    if (!reset) begin
      mHalt = 0; mTrapped = 0; mReported = 0; mCode = 0;
      mPc = 0; mCycle = 0; mInstr = 0; mReportAt = 0; mIdle = 0;
      return;
    end
    if (mReported) return;
    mCycle = mCycle + 1;
    if (mTrapped) begin
      if (mCycle == mReportAt) mReported = 1;
      return;
    end
    firstTrap = -1;
    for (int i = 1; i >= 0; i--)
      if (commit_valid[i] && commit_is_trap[i]) firstTrap = i;
    nKeep = 0;
    for (int i = 0; i < 2; i++)
      if (commit_valid[i] && (firstTrap < 0 || i <= firstTrap)) nKeep++;
    mInstr = mInstr + 64'(nKeep);
    if (firstTrap >= 0) begin
      mCode = commit_a0[64*firstTrap +: 32];
      mPc   = commit_pc[64*firstTrap +: 64];
      mTrapped = 1; mHalt = 1; mReportAt = mCycle + DRAIN_CYC;
    end else if (commit_valid != 0) begin
      mPc   = commit_valid[1] ? commit_pc[127:64] : commit_pc[63:0];
      mIdle = 0;
    end else begin
      mIdle++;
      if (mIdle == TIMEOUT) begin
        mCode = 32'h0000_DEAD;
        mTrapped = 1; mHalt = 1; mReportAt = mCycle + DRAIN_CYC;
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] v, input logic [1:0] t,
                      input logic [63:0] p0, input logic [63:0] p1,
                      input logic [63:0] x0, input logic [63:0] x1);
    reset = r;
    commit_valid = v;
    commit_is_trap = t;
    commit_pc = {p1, p0};
    commit_a0 = {x1, x0};
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++)
      step(1'b0, 2'b11, 2'b01, 64'h1234, 64'h5678, 64'h9, 64'h9);
    total++;
    if ({halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt} !== 226'd0) begin
      bad++;
      $display("FAIL reset_zero: got halt=%0b trap=%0b code=%h pc=%h cyc=%0d ins=%0d want all 0",
               halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt);
    end
  endtask

  task automatic test_commit_stream();
    for (int k = 0; k < 10; k++)
      step(1'b1, 2'b01, 2'b00, 64'h8000_0000 + 64'(4*k), 64'hDEAD_0000, 64'($urandom), 64'd0);
    total++;
    if (instrCnt !== 64'd10 || cycleCnt !== 64'd10) begin
      bad++;
      $display("FAIL stream_counts: got ins=%0d cyc=%0d want 10 10", instrCnt, cycleCnt);
    end
    total++;
    if (trapPC !== 64'h8000_0024) begin
      bad++;
      $display("FAIL stream_pc: got %h want 80000024", trapPC);
    end
    total++;
    if (halt_req !== 1'b0 || isNutShellTrap !== 1'b0) begin
      bad++;
      $display("FAIL stream_flags: got halt=%0b trap=%0b want 0 0", halt_req, isNutShellTrap);
    end
  endtask

  task automatic test_trap_slot1();
    for (int k = 10; k < 20; k++)
      step(1'b1, 2'b01, 2'b00, 64'h8000_0000 + 64'(4*k), 64'd0, 64'd0, 64'd0);
    step(1'b1, 2'b11, 2'b10, 64'h8000_0050, 64'h8000_0054, 64'h77, 64'h0);
    total++;
    if (halt_req !== 1'b1 || isNutShellTrap !== 1'b0 || cycleCnt !== 64'd21) begin
      bad++;
      $display("FAIL trap1_halt: got halt=%0b trap=%0b cyc=%0d want 1 0 21",
               halt_req, isNutShellTrap, cycleCnt);
    end
    total++;
    if (trapCode !== 32'd0 || trapPC !== 64'h8000_0054 || instrCnt !== 64'd22) begin
      bad++;
      $display("FAIL trap1_report: got code=%h pc=%h ins=%0d want 0 80000054 22",
               trapCode, trapPC, instrCnt);
    end
    idle(3);
    total++;
    if (isNutShellTrap !== 1'b0) begin
      bad++;
      $display("FAIL trap1_early: got trap=%0b want 0 at cycle 24", isNutShellTrap);
    end
    idle(1);
    total++;
    if (isNutShellTrap !== 1'b1 || cycleCnt !== 64'd25) begin
      bad++;
      $display("FAIL trap1_latency: got trap=%0b cyc=%0d want 1 25", isNutShellTrap, cycleCnt);
    end
    idle(5);
    total++;
    if (cycleCnt !== 64'd25 || instrCnt !== 64'd22) begin
      bad++;
      $display("FAIL trap1_frozen: got cyc=%0d ins=%0d want 25 22", cycleCnt, instrCnt);
    end
  endtask

  task automatic test_dual_trap();
    step(1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
    for (int k = 0; k < 3; k++)
      step(1'b1, 2'b01, 2'b00, 64'h100 + 64'(8*k), 64'd0, 64'd0, 64'd0);
    step(1'b1, 2'b11, 2'b11, 64'h2000, 64'h2004, 64'hABCD_0000_0000_0007, 64'd9);
    total++;
    if (trapCode !== 32'd7 || trapPC !== 64'h2000 || instrCnt !== 64'd4 || halt_req !== 1'b1) begin
      bad++;
      $display("FAIL dual_trap: got code=%h pc=%h ins=%0d halt=%0b want 7 2000 4 1",
               trapCode, trapPC, instrCnt, halt_req);
    end
    idle(DRAIN_CYC);
    total++;
    if ({halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt} !==
        {mHalt, mReported, mCode, mPc, mCycle, mInstr} || isNutShellTrap !== 1'b1) begin
      bad++;
      $display("FAIL dual_report: got trap=%0b cyc=%0d ins=%0d want trap=1 cyc=%0d ins=%0d",
               isNutShellTrap, cycleCnt, instrCnt, mCycle, mInstr);
    end
  endtask

  task automatic test_watchdog();
    step(1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
    idle(15);
    total++;
    if (halt_req !== 1'b0) begin
      bad++;
      $display("FAIL wdog_early: got halt=%0b want 0 after 15 idle", halt_req);
    end
    idle(1);
    total++;
    if (halt_req !== 1'b1 || trapCode !== 32'h0000_DEAD || trapPC !== 64'd0 || instrCnt !== 64'd0) begin
      bad++;
      $display("FAIL wdog_fire: got halt=%0b code=%h pc=%h ins=%0d want 1 0000dead 0 0",
               halt_req, trapCode, trapPC, instrCnt);
    end
    step(1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
    idle(14);
    step(1'b1, 2'b10, 2'b00, 64'd0, 64'h4444, 64'd0, 64'd0);
    idle(15);
    total++;
    if (halt_req !== 1'b0) begin
      bad++;
      $display("FAIL wdog_kick: got halt=%0b want 0 after kick + 15 idle", halt_req);
    end
    idle(1);
    total++;
    if (halt_req !== 1'b1 || trapPC !== 64'h4444 || trapCode !== 32'h0000_DEAD || instrCnt !== 64'd1) begin
      bad++;
      $display("FAIL wdog_refire: got halt=%0b pc=%h code=%h ins=%0d want 1 4444 0000dead 1",
               halt_req, trapPC, trapCode, instrCnt);
    end
    idle(DRAIN_CYC);
    total++;
    if (isNutShellTrap !== 1'b1 || cycleCnt !== 64'd35) begin
      bad++;
      $display("FAIL wdog_report: got trap=%0b cyc=%0d want 1 35", isNutShellTrap, cycleCnt);
    end
  endtask

  task automatic test_drain_commits();
    step(1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
    for (int k = 0; k < 5; k++)
      step(1'b1, 2'b11, 2'b00, 64'h300 + 64'(8*k), 64'h304 + 64'(8*k), 64'd0, 64'd0);
    step(1'b1, 2'b01, 2'b00, 64'h400, 64'd0, 64'h55, 64'd0);
    step(1'b1, 2'b01, 2'b01, 64'h404, 64'd0, 64'h55, 64'd0);
    for (int k = 0; k < DRAIN_CYC; k++) begin
      step(1'b1, 2'($urandom_range(1, 3)), 2'($urandom), 64'($urandom), 64'($urandom),
           64'($urandom), 64'($urandom));
      total++;
      if (instrCnt !== 64'd12 || trapPC !== 64'h404 || trapCode !== 32'h55) begin
        bad++;
        $display("FAIL drain_ignore[%0d]: got ins=%0d pc=%h code=%h want 12 404 55",
                 k, instrCnt, trapPC, trapCode);
      end
    end
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 2'($urandom), 2'($urandom), 64'($urandom), 64'($urandom),
           64'($urandom), 64'($urandom));
      total++;
      if ({halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt} !==
          {1'b1, 1'b1, 32'h55, 64'h404, 64'd11, 64'd12}) begin
        bad++;
        $display("FAIL halt_stable[%0d]: got halt=%0b trap=%0b code=%h pc=%h cyc=%0d ins=%0d want 1 1 55 404 11 12",
                 k, halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt);
      end
    end
  endtask

  task automatic test_reset_midstate();
    step(1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
    idle(2);
    step(1'b1, 2'b01, 2'b01, 64'h500, 64'd0, 64'h3, 64'd0);
    idle(2);
    step(1'b0, 2'b11, 2'b00, 64'h600, 64'h604, 64'd0, 64'd0);
    total++;
    if ({halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt} !== 226'd0) begin
      bad++;
      $display("FAIL reset_in_drain: got halt=%0b code=%h pc=%h cyc=%0d ins=%0d want all 0",
               halt_req, trapCode, trapPC, cycleCnt, instrCnt);
    end
    idle(1);
    total++;
    if (cycleCnt !== 64'd1 || halt_req !== 1'b0 || instrCnt !== 64'd0) begin
      bad++;
      $display("FAIL restart_drain: got cyc=%0d halt=%0b ins=%0d want 1 0 0", cycleCnt, halt_req, instrCnt);
    end
    step(1'b1, 2'b01, 2'b01, 64'h700, 64'd0, 64'h1, 64'd0);
    idle(DRAIN_CYC + 2);
    step(1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
    total++;
    if ({halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt} !== 226'd0) begin
      bad++;
      $display("FAIL reset_in_halt: got halt=%0b trap=%0b cyc=%0d ins=%0d want all 0",
               halt_req, isNutShellTrap, cycleCnt, instrCnt);
    end
    step(1'b1, 2'b10, 2'b00, 64'd0, 64'h800, 64'd0, 64'd0);
    total++;
    if (cycleCnt !== 64'd1 || instrCnt !== 64'd1 || trapPC !== 64'h800) begin
      bad++;
      $display("FAIL restart_halt: got cyc=%0d ins=%0d pc=%h want 1 1 800", cycleCnt, instrCnt, trapPC);
    end
    force dut.instrCntReg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instrCntReg;
    mInstr = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1'b1, 2'b11, 2'b00, 64'h900, 64'h904, 64'd0, 64'd0);
    total++;
    if (instrCnt !== 64'd1) begin
      bad++;
      $display("FAIL instr_wrap: got %0d want 1", instrCnt);
    end
  endtask

  task automatic test_random();
    int idleRun;
    logic [1:0] v, t;
    for (int ep = 0; ep < 6; ep++) begin
      step(1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
      idleRun = 0;
      for (int c = 0; c < 150; c++) begin
        if (idleRun == 0 && $urandom_range(0, 99) < 3) idleRun = $urandom_range(8, 20);
        if (idleRun > 0) begin
          idleRun--;
          v = 2'b00;
        end else begin
          v = 2'($urandom);
        end
        t[0] = ($urandom_range(0, 99) < 3);
        t[1] = ($urandom_range(0, 99) < 3);
        step(1'b1, v, t, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom});
        total++;
        if ({halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt} !==
            {mHalt, mReported, mCode, mPc, mCycle, mInstr}) begin
          bad++;
          $display("FAIL random[%0d.%0d]: got h=%0b t=%0b code=%h pc=%h cyc=%0d ins=%0d want h=%0b t=%0b code=%h pc=%h cyc=%0d ins=%0d",
                   ep, c, halt_req, isNutShellTrap, trapCode, trapPC, cycleCnt, instrCnt,
                   mHalt, mReported, mCode, mPc, mCycle, mInstr);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    commit_valid = '0;
    commit_is_trap = '0;
    commit_pc = '0;
    commit_a0 = '0;
    @(negedge clk);
    test_reset();
    test_commit_stream();
    test_trap_slot1();
    test_dual_trap();
    test_watchdog();
    test_drain_commits();
    test_reset_midstate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
